dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port data memory.
- Requester 0 is the core load/store path; requester 1 is the debug/loader port.
- Serialises accesses with round-robin fairness and drives the memory's address, write-data, read-enable and write-enable pins.
- Registers read data and returns it to the winning requester with a valid pulse.

Parameters:
register_count, 32, number of memory words; address width AW = $clog2(register_count)
data_length, 32, word width DW
LOCK_MAX, 4, maximum consecutive locked grants to one requester (used only with the optional feature)

Ports:
clk  input  1  clock, all state on posedge
rst  input  1  synchronous, active-high reset
m0_req  input  1  requester 0 access request
m0_we  input  1  requester 0: 1 = write, 0 = read
m0_addr  input  AW  requester 0 word address
m0_wdata  input  DW  requester 0 write data
m0_gnt  output  1  requester 0 accepted (one-cycle pulse)
m0_rvalid  output  1  requester 0 read data valid (one-cycle pulse)
m0_rdata  output  DW  requester 0 read data
m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for requester 1
mem_addr  output  AW  memory address
mem_wdata  output  DW  memory write data
mem_r_ctrl  output  1  memory read enable
mem_w_ctrl  output  1  memory write enable
mem_rdata  input  DW  memory combinational read data

Behaviour:
- Reset: FSM enters IDLE; priority pointer favours m0; latched owner/we/addr/wdata cleared. All outputs are 0: gnt, rvalid, rdata, mem_*.
- FSM states: IDLE, ACCESS, RESP.
- Arbitration samples mX_req in IDLE and RESP only; requests during ACCESS are ignored.
- IDLE or RESP with any req: pick the winner, latch owner, we, addr and wdata, then go to ACCESS. No req: IDLE→IDLE, RESP→IDLE.
- Winner selection: single requester wins outright. Both requesting: the pointer side wins, then the pointer flips to the loser.
- ACCESS (exactly 1 cycle), registered-request latency 1:
  - mX_gnt=1 for the owner only.
  - mem_addr and mem_wdata come from the latches; mem_r_ctrl = !we; mem_w_ctrl = we & !rst.
  - The write commits at the closing edge.
  - Read: mem_rdata is captured into the owner's rdata register at that edge.
  - Next state RESP.
- RESP:
  - Read: owner's mX_rvalid=1, with mX_rdata holding the captured word.
  - Write: no rvalid pulse.
  - Arbitration for the next access runs in the same cycle.
- mX_rdata holds its last value until the next read by that requester.
- Throughput: one access per 2 cycles when saturated. Read latency: req cycle N → gnt N+1 → rvalid N+2.
- Requester protocol:
  - Hold req and fields stable until gnt is seen.
  - Drop req no later than the RESP cycle unless issuing a new request; a req still high in RESP is a new request.
- Outside ACCESS, mem_addr, mem_wdata, mem_r_ctrl and mem_w_ctrl are 0.
- Reset mid-operation:
  - rst high in ACCESS suppresses mem_w_ctrl that cycle, so no write occurs.
  - gnt, rvalid and rdata are cleared next cycle; the FSM returns to IDLE with the pointer reset to m0.
- No combinational path from req to gnt or to any mem_* output.

Optional Feature:
DMEM_ARB_LOCK_EN
- Defined:
  - Adds inputs m0_lock and m1_lock (1 bit each) and a lock counter of width $clog2(LOCK_MAX+1).
  - In RESP, if the current owner has req & lock high, it wins regardless of the pointer; the pointer does not move and the counter increments.
  - When the counter reaches LOCK_MAX and the other side is requesting, the other side wins, the counter clears and normal rotation resumes.
  - The counter clears on any non-locked grant and on reset.
- Undefined: no lock ports, no counter; pure round-robin.

Test Plan:
- Reset, then m0 write addr 5 data 0xDEADBEEF, then m0 read addr 5 → m0_gnt pulses; read gives m0_rvalid with m0_rdata=0xDEADBEEF 2 cycles after the read req; m1_* stay 0.
- m0 and m1 both request continuously (reads, addr 1 and 2) → grants alternate m0, m1, m0, m1, one per 2 cycles; rdata routed to the correct port.
- m1 only, read of addr 31 (wrap boundary) → mem_addr=31, m1_rvalid at N+2; pointer unchanged for later ties.
- rst asserted during an m1 write ACCESS cycle to addr 7 → mem_w_ctrl=0, addr 7 unchanged on readback; all outputs 0 the next cycle.
- Write followed by a read in back-to-back RESP→ACCESS by m0 → mem_w_ctrl high for exactly 1 cycle; no rvalid for the write; rvalid for the read.
- With DMEM_ARB_LOCK_EN: m0 holds lock with continuous reqs while m1 requests → m0 granted 1 + LOCK_MAX times consecutively, then m1 is granted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sequencer giving two requesters the single-port data memory.
// Build macro DMEM_ARB_LOCK_EN adds lock inputs and bounded locked re-grants.
module dmem_arbiter #(
  parameter int register_count = 32,
  parameter int data_length    = 32,
  parameter int LOCK_MAX       = 4,
  localparam int AW = $clog2(register_count),
  localparam int DW = data_length
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
`ifdef DMEM_ARB_LOCK_EN
  input  logic          m0_lock,
  input  logic          m1_lock,
`endif
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_r_ctrl,
  output logic          mem_w_ctrl
);

  if (LOCK_MAX < 1) begin : g_lock_max_chk
    $error("LOCK_MAX must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  logic          ptr;
  logic          owner;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          arb_go;
  logic          win;
  logic          nptr;
  logic          acc;

  assign arb_go = (state == IDLE || state == RESP)
                  && (m0_req || m1_req);
  assign acc    = (state == ACCESS);

`ifdef DMEM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic [CW-1:0] lock_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          own_lock;
  logic          oth_req;
  logic          cnt_full;

  assign own_lock = owner ? (m1_req & m1_lock)
                          : (m0_req & m0_lock);
  assign oth_req  = owner ? m0_req : m1_req;
  assign cnt_full = (lock_cnt == CW'(LOCK_MAX));
`endif

  // Ties go to the pointer side; the pointer then favours the loser.
  always_comb begin
    win  = m1_req;
    nptr = ptr;
    if (m0_req && m1_req) begin
      win  = ptr;
      nptr = ~ptr;
    end
`ifdef DMEM_ARB_LOCK_EN
    cnt_nxt = '0;
    unique case (1'b1)
      (state == RESP && own_lock && !cnt_full): begin
        win     = owner;
        nptr    = ptr;
        cnt_nxt = lock_cnt + 1'b1;
      end
      (state == RESP && cnt_full && oth_req): begin
        win  = ~owner;
        nptr = owner;
      end
      default: ;
    endcase
`endif
  end

`ifdef DMEM_ARB_LOCK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_cnt <= '0;
    end else if (arb_go) begin
      lock_cnt <= cnt_nxt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      unique case (state)
        IDLE, RESP: begin
          if (arb_go) begin
            state   <= ACCESS;
            owner   <= win;
            ptr     <= nptr;
            we_q    <= win ? m1_we    : m0_we;
            addr_q  <= win ? m1_addr  : m0_addr;
            wdata_q <= win ? m1_wdata : m0_wdata;
            m0_gnt  <= ~win;
            m1_gnt  <= win;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (!we_q) begin
            if (owner) begin
              m1_rvalid <= 1'b1;
              m1_rdata  <= mem_rdata;
            end else begin
              m0_rvalid <= 1'b1;
              m0_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory pins are live only in ACCESS; reset vetoes an in-flight write.
  assign mem_addr   = acc ? addr_q  : '0;
  assign mem_wdata  = acc ? wdata_q : '0;
  assign mem_r_ctrl = acc & ~we_q;
  assign mem_w_ctrl = acc & we_q & ~rst;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: random and directed traffic on both ports,
// checked by a transaction-level reference model and scoreboard.
module tb_dmem_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0;
  logic          m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req = 1'b0;
  logic          m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_r_ctrl;
  logic          mem_w_ctrl;
`ifdef DMEM_ARB_LOCK_EN
  logic          m0_lock = 1'b0;
  logic          m1_lock = 1'b0;
`endif

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
`ifdef DMEM_ARB_LOCK_EN
    .m0_lock   (m0_lock),
    .m1_lock   (m1_lock),
`endif
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_r_ctrl(mem_r_ctrl),
    .mem_w_ctrl(mem_w_ctrl)
  );

  always #5 clk = ~clk;

  // Memory device seen by the DUT.
  logic [DW-1:0] dev_mem [32];
  assign mem_rdata = dev_mem[mem_addr];
  always @(posedge clk) begin
    if (mem_w_ctrl) dev_mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    bit            port;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } acc_t;

  typedef struct {
    bit            port;
    logic [DW-1:0] data;
  } rv_t;

  acc_t          gnt_q [$];
  rv_t           rv_q [$];
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] exp_rd [2];
  bit            fav;
  bit            busy;
  acc_t          cur;
  acc_t          e;
  rv_t           r;
  int            checks = 0;
  int            passes = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    else
      passes++;
  endtask

  // Reference model: an access takes two cycles, so after a decision the
  // next edge only closes that access and the one after arbitrates again.
  always @(posedge clk) begin
    if (busy) begin
      busy = 1'b0;
      if (!rst) begin
        if (cur.we) begin
          ref_mem[cur.addr] = cur.wdata;
        end else begin
          rv_q.push_back('{cur.port, ref_mem[cur.addr]});
          exp_rd[cur.port] = ref_mem[cur.addr];
        end
      end
    end else if (!rst && (m0_req || m1_req)) begin
      if (m0_req && m1_req) begin
        cur.port = fav;
        fav = !fav;
      end else begin
        cur.port = m1_req;
      end
      cur.we    = cur.port ? m1_we    : m0_we;
      cur.addr  = cur.port ? m1_addr  : m0_addr;
      cur.wdata = cur.port ? m1_wdata : m0_wdata;
      gnt_q.push_back(cur);
      busy = 1'b1;
    end
    if (rst) begin
      fav = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
    end
  end

  // Monitor: compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (gnt_q.size() != 0) begin
      e = gnt_q.pop_front();
      chk("gnt", {m1_gnt, m0_gnt}, e.port ? 2 : 1);
      chk("mem_addr", mem_addr, e.addr);
      chk("mem_wdata", mem_wdata, e.wdata);
      chk("mem_w_ctrl", mem_w_ctrl, e.we & !rst);
      chk("mem_r_ctrl", mem_r_ctrl, !e.we);
    end else begin
      chk("idle_outs", {m1_gnt, m0_gnt, mem_r_ctrl, mem_w_ctrl,
                        mem_addr, mem_wdata}, 0);
    end
    if (rv_q.size() != 0) begin
      r = rv_q.pop_front();
      chk("rvalid", {m1_rvalid, m0_rvalid}, r.port ? 2 : 1);
      chk("rdata", r.port ? m1_rdata : m0_rdata, r.data);
    end else begin
      chk("rvalid_idle", {m1_rvalid, m0_rvalid}, 0);
    end
    chk("m0_rdata_hold", m0_rdata, exp_rd[0]);
    chk("m1_rdata_hold", m1_rdata, exp_rd[1]);
  end

  task automatic set_port(input bit p, input bit req, input bit we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p) begin
      m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
    end
  endtask

  // Present one request, hold it until granted, then idle for gap cycles
  // (gap 0 leaves req high for the caller's next request).
  task automatic drive(input bit p, input bit we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int gap,
                       input bit kill);
    bit got = 1'b0;
    set_port(p, 1'b1, we, a, d);
    for (int n = 0; n < 60 && !got; n++) begin
      @(posedge clk); #1;
      got = p ? m1_gnt : m0_gnt;
    end
    if (!got) begin
      checks++;
      $display("FAIL grant_timeout port %0d: got no gnt, required gnt", p);
      set_port(p, 1'b0, 1'b0, '0, '0);
      return;
    end
    if (kill) begin
      rst = 1'b1;
      set_port(p, 1'b0, 1'b0, '0, '0);
      @(posedge clk); #1;
      rst = 1'b0;
      return;
    end
    if (gap > 0) begin
      set_port(p, 1'b0, 1'b0, '0, '0);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic rand_traffic(input bit p, input int n);
    for (int i = 0; i < n; i++)
      drive(p, 1'($urandom_range(0, 1)), AW'($urandom),
            $urandom, (i == n - 1) ? 1 : $urandom_range(0, 3), 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      dev_mem[i] = $urandom;
      ref_mem[i] = dev_mem[i];
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1, 1'b0);
    drive(1'b0, 1'b0, 5'd5, 32'h0, 3, 1'b0);
    chk("m0_read_back", m0_rdata, 32'hDEADBEEF);

    fork
      for (int i = 0; i < 4; i++)
        drive(1'b0, 1'b0, 5'd1, 32'h0, (i == 3) ? 1 : 0, 1'b0);
      for (int i = 0; i < 4; i++)
        drive(1'b1, 1'b0, 5'd2, 32'h0, (i == 3) ? 1 : 0, 1'b0);
    join
    repeat (2) begin @(posedge clk); #1; end

    drive(1'b1, 1'b0, 5'd31, 32'h0, 2, 1'b0);
    fork
      drive(1'b0, 1'b0, 5'd3, 32'h0, 1, 1'b0);
      drive(1'b1, 1'b0, 5'd4, 32'h0, 1, 1'b0);
    join
    repeat (2) begin @(posedge clk); #1; end

    drive(1'b1, 1'b1, 5'd7, 32'hA5A5_0F0F, 0, 1'b1);
    repeat (2) begin @(posedge clk); #1; end
    drive(1'b1, 1'b0, 5'd7, 32'h0, 2, 1'b0);
    chk("addr7_unchanged", m1_rdata, ref_mem[7]);

    drive(1'b0, 1'b1, 5'd9, 32'h1234_5678, 0, 1'b0);
    drive(1'b0, 1'b0, 5'd9, 32'h0, 3, 1'b0);
    chk("wr_rd_b2b", m0_rdata, 32'h1234_5678);

    fork
      rand_traffic(1'b0, 150);
      rand_traffic(1'b1, 150);
    join
    repeat (5) begin @(posedge clk); #1; end
    chk("drain", gnt_q.size() + rv_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
